// File: rtl/matrix_mul_ctrl_pkg.sv
// matrix_mul_ctrl_pkg: job descriptor, BRAM address types, FSM states.
// Shared by matrix_mul_ctrl and matrix_mul_pe_array.
package matrix_mul_ctrl_pkg;

  localparam int ADDR_W   = 14;
  localparam int LINE_W   = 14;
  localparam int N_W      = 12;
  localparam int WR_LANES = 4;
  localparam int WR_STEP  = 16;

  typedef logic [ADDR_W-1:0] feature_bram_addr_t;
  typedef logic [ADDR_W-1:0] weight_bram_addr_t;
  typedef logic [ADDR_W-1:0] output_bram_addr_t;

  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] a_line_size;
    logic [LINE_W-1:0] b_line_size;
    logic [LINE_W-1:0] c_line_size;
    logic [N_W-1:0]    matrix_n;
  } matrix_mul_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/matrix_mul_pe_array.sv
// matrix_mul_pe_array: ROW_SIZE x COLUMN_SIZE MAC grid with product pipe.
// Ports: clk, rst (sync high), clear, in_valid, a/b lanes in; acc grid out.
// MATRIX_MUL_SIGNED_EN selects two's-complement operands.
module matrix_mul_pe_array
  import matrix_mul_ctrl_pkg::*;
#(
  parameter int MULER_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int MULER_DELAY  = 1,
  parameter int ROW_SIZE     = 8,
  parameter int COLUMN_SIZE  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic in_valid,
  input  logic [ROW_SIZE*MULER_WIDTH-1:0] a,
  input  logic [COLUMN_SIZE*MULER_WIDTH-1:0] b,
  output logic [ROW_SIZE-1:0][COLUMN_SIZE-1:0][OUTPUT_WIDTH-1:0] acc
);

  localparam int MW = MULER_WIDTH;
  localparam int PW = 2*MULER_WIDTH;
  localparam int OW = OUTPUT_WIDTH;

  logic [PW-1:0] prod [ROW_SIZE][COLUMN_SIZE];
  logic [PW-1:0] pipe [MULER_DELAY][ROW_SIZE][COLUMN_SIZE];
  logic [MULER_DELAY-1:0] vpipe;

  // Low PW bits of the extended operands give the exact product.
  function automatic logic [PW-1:0] mul(
    input logic [MW-1:0] x,
    input logic [MW-1:0] y
  );
`ifdef MATRIX_MUL_SIGNED_EN
    return $signed({{MW{x[MW-1]}}, x}) *
           $signed({{MW{y[MW-1]}}, y});
`else
    return {{MW{1'b0}}, x} * {{MW{1'b0}}, y};
`endif
  endfunction

  function automatic logic [OW-1:0] extend(
    input logic [PW-1:0] p
  );
`ifdef MATRIX_MUL_SIGNED_EN
    return {{(OW-PW){p[PW-1]}}, p};
`else
    return {{(OW-PW){1'b0}}, p};
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < ROW_SIZE; i++)
      for (int j = 0; j < COLUMN_SIZE; j++)
        prod[i][j] = mul(a[i*MW +: MW], b[j*MW +: MW]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
      for (int s = 0; s < MULER_DELAY; s++)
        for (int i = 0; i < ROW_SIZE; i++)
          for (int j = 0; j < COLUMN_SIZE; j++)
            pipe[s][i][j] <= '0;
      acc <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int s = 1; s < MULER_DELAY; s++)
        vpipe[s] <= vpipe[s-1];
      for (int i = 0; i < ROW_SIZE; i++)
        for (int j = 0; j < COLUMN_SIZE; j++)
          pipe[0][i][j] <= prod[i][j];
      for (int s = 1; s < MULER_DELAY; s++)
        for (int i = 0; i < ROW_SIZE; i++)
          for (int j = 0; j < COLUMN_SIZE; j++)
            pipe[s][i][j] <= pipe[s-1][i][j];
      if (clear) begin
        acc <= '0;
      end else if (vpipe[MULER_DELAY-1]) begin
        for (int i = 0; i < ROW_SIZE; i++)
          for (int j = 0; j < COLUMN_SIZE; j++)
            acc[i][j] <= acc[i][j] +
              extend(pipe[MULER_DELAY-1][i][j]);
      end
    end
  end

endmodule

// File: rtl/matrix_mul_ctrl.sv
// matrix_mul_ctrl: output-stationary 8x8 tile controller (fetch, MAC, drain, write C).
// Ports: clk, rst (sync high), ctrl_info job in; feature/weight read addr + req_valid out,
// feature/weight resp in; output_addr/output_data/output_we out. Macro: MATRIX_MUL_SIGNED_EN.
module matrix_mul_ctrl
  import matrix_mul_ctrl_pkg::*;
#(
  parameter int MULER_WIDTH       = 8,
  parameter int NUM_WIDTH         = 12,
  parameter int OUTPUT_WIDTH      = 32,
  parameter int MULER_DELAY       = 1,
  parameter int ROW_SIZE          = 8,
  parameter int COLUMN_SIZE       = 8,
  parameter int BRAM_READ_LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  output logic req_valid,
  input  matrix_mul_ctrl_t ctrl_info,
  output feature_bram_addr_t feature_addr,
  input  logic [ROW_SIZE*MULER_WIDTH-1:0] feature_resp,
  output weight_bram_addr_t weight_addr,
  input  logic [COLUMN_SIZE*MULER_WIDTH-1:0] weight_resp,
  output output_bram_addr_t output_addr,
  output logic [WR_LANES*OUTPUT_WIDTH-1:0] output_data,
  output logic output_we
);

  localparam int OW = OUTPUT_WIDTH;
  localparam int HN = COLUMN_SIZE / WR_LANES;
  localparam int HW = (HN > 1) ? $clog2(HN) : 1;
  localparam int RW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int CW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
  localparam int DRAIN_LAST = BRAM_READ_LATENCY + MULER_DELAY;

  state_t state, state_n;

  logic [LINE_W-1:0] a_q, b_q, c_q;
  logic [NUM_WIDTH-1:0] n_q, k, k_last;
  feature_bram_addr_t fa;
  weight_bram_addr_t wa;
  output_bram_addr_t row_base;
  logic [7:0] dcnt;
  logic [RW-1:0] r;
  logic [HW-1:0] h;
  logic [BRAM_READ_LATENCY-1:0] rd_pipe;
  logic fetch_done, drain_done, write_done, pe_clear;
  logic [ROW_SIZE-1:0][COLUMN_SIZE-1:0][OW-1:0] acc;
  logic [WR_LANES*OW-1:0] wr_word;

  assign k_last     = n_q - NUM_WIDTH'(1);
  assign fetch_done = (k == k_last);
  assign drain_done = (dcnt == 8'(DRAIN_LAST));
  assign write_done = (r == RW'(ROW_SIZE-1)) &&
                      (h == HW'(HN-1));
  assign pe_clear   = (state == ST_IDLE) && ctrl_info.valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (ctrl_info.valid)
          state_n = (ctrl_info.matrix_n == '0) ?
                    ST_DRAIN : ST_FETCH;
      ST_FETCH: if (fetch_done) state_n = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_n = ST_WRITE;
      ST_WRITE: if (write_done) state_n = ST_IDLE;
    endcase
  end

  // One write word: four adjacent columns of row r.
  always_comb begin
    wr_word = '0;
    for (int m = 0; m < WR_LANES; m++)
      wr_word[m*OW +: OW] = acc[r][CW'(WR_LANES*h + m)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      n_q          <= '0;
      k            <= '0;
      fa           <= '0;
      wa           <= '0;
      row_base     <= '0;
      dcnt         <= '0;
      r            <= '0;
      h            <= '0;
      rd_pipe      <= '0;
      req_valid    <= 1'b0;
      feature_addr <= '0;
      weight_addr  <= '0;
      output_we    <= 1'b0;
      output_addr  <= '0;
      output_data  <= '0;
    end else begin
      req_valid  <= (state == ST_FETCH);
      output_we  <= (state == ST_WRITE);
      rd_pipe[0] <= req_valid;
      for (int s = 1; s < BRAM_READ_LATENCY; s++)
        rd_pipe[s] <= rd_pipe[s-1];
      unique case (state)
        ST_IDLE: begin
          if (ctrl_info.valid) begin
            a_q  <= ctrl_info.a_line_size;
            b_q  <= ctrl_info.b_line_size;
            c_q  <= ctrl_info.c_line_size;
            n_q  <= NUM_WIDTH'(ctrl_info.matrix_n);
            k    <= '0;
            fa   <= '0;
            wa   <= '0;
            dcnt <= '0;
          end
        end
        ST_FETCH: begin
          feature_addr <= fa;
          weight_addr  <= wa;
          fa <= fa + a_q;
          wa <= wa + b_q;
          k  <= k + NUM_WIDTH'(1);
        end
        ST_DRAIN: begin
          dcnt     <= dcnt + 8'd1;
          r        <= '0;
          h        <= '0;
          row_base <= '0;
        end
        ST_WRITE: begin
          output_addr <= row_base +
            (output_bram_addr_t'(h) << 4);
          output_data <= wr_word;
          if (h == HW'(HN-1)) begin
            h        <= '0;
            r        <= r + RW'(1);
            row_base <= row_base + c_q;
          end else begin
            h <= h + HW'(1);
          end
        end
      endcase
    end
  end

  matrix_mul_pe_array #(
    .MULER_WIDTH (MULER_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .MULER_DELAY (MULER_DELAY),
    .ROW_SIZE    (ROW_SIZE),
    .COLUMN_SIZE (COLUMN_SIZE)
  ) u_pe (
    .clk     (clk),
    .rst     (rst),
    .clear   (pe_clear),
    .in_valid(rd_pipe[BRAM_READ_LATENCY-1]),
    .a       (feature_resp),
    .b       (weight_resp),
    .acc     (acc)
  );

endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// tb_matrix_mul_ctrl: randomized jobs against a sum-of-products reference.
// BRAM model: 3-cycle latency, word index = addr[5:3].
module tb_matrix_mul_ctrl;
  import matrix_mul_ctrl_pkg::*;

  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid, output_we;
  matrix_mul_ctrl_t ctrl_info;
  feature_bram_addr_t feature_addr;
  weight_bram_addr_t weight_addr;
  output_bram_addr_t output_addr;
  logic [63:0] feature_resp, weight_resp;
  logic [127:0] output_data;

  logic [63:0] fmem [8];
  logic [63:0] wmem [8];
  logic [63:0] fq [3];
  logic [63:0] wq [3];
  logic [31:0] exp_c [8][8];
  int vec = 0, err = 0, cyc = 0, launch_cyc = 0;

  typedef struct {
    int cyc;
    logic [13:0] fa;
    logic [13:0] wa;
  } rd_t;
  typedef struct {
    int cyc;
    logic [13:0] addr;
    logic [127:0] data;
  } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];

  matrix_mul_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .ctrl_info(ctrl_info),
    .feature_addr(feature_addr), .feature_resp(feature_resp),
    .weight_addr(weight_addr), .weight_resp(weight_resp),
    .output_addr(output_addr), .output_data(output_data),
    .output_we(output_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    fq[0] <= fmem[feature_addr[5:3]];
    wq[0] <= wmem[weight_addr[5:3]];
    fq[1] <= fq[0];
    wq[1] <= wq[0];
    fq[2] <= fq[1];
    wq[2] <= wq[1];
  end
  assign feature_resp = fq[2];
  assign weight_resp  = wq[2];

  always @(negedge clk) begin
    if (!rst && req_valid)
      rd_q.push_back('{cyc, feature_addr, weight_addr});
    if (!rst && output_we)
      wr_q.push_back('{cyc, output_addr, output_data});
  end

  function automatic int lane(input logic [63:0] w, input int i);
    logic [7:0] e;
    e = w[i*8 +: 8];
`ifdef MATRIX_MUL_SIGNED_EN
    return int'($signed(e));
`else
    return int'(e);
`endif
  endfunction

  // C[i][j] = sum over k of A[i][k]*B[k][j]; word k holds column/row k.
  task automatic compute_model(input int n);
    logic [31:0] s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = 32'd0;
        for (int k = 0; k < n; k++)
          s = s + 32'(lane(fmem[k], i) * lane(wmem[k], j));
        exp_c[i][j] = s;
      end
  endtask

  task automatic do_job(input string name, input int n,
                        input int c_line, input bit hold);
    int jobs, t, idx, r, h;
    logic [127:0] ew;
    logic [13:0] ea;
    jobs = hold ? 2 : 1;
    t = 0;
    compute_model(n);
    @(negedge clk); #1;
    rd_q.delete();
    wr_q.delete();
    ctrl_info.valid       = 1'b1;
    ctrl_info.a_line_size = 14'd8;
    ctrl_info.b_line_size = 14'd8;
    ctrl_info.c_line_size = 14'(c_line);
    ctrl_info.matrix_n    = 12'(n);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    launch_cyc = cyc;
    if (!hold) begin
      ctrl_info.valid       = 1'b0;
      ctrl_info.a_line_size = 14'($urandom);
      ctrl_info.b_line_size = 14'($urandom);
      ctrl_info.c_line_size = 14'($urandom);
      ctrl_info.matrix_n    = 12'($urandom);
    end
    while (wr_q.size() < NW*jobs && t < 3000) begin
      @(negedge clk); #1;
      t++;
      if (hold && rd_q.size() > n) ctrl_info.valid = 1'b0;
    end
    repeat (10) @(negedge clk);
    #1;
    vec++;
    if (t >= 3000) begin
      err++;
      $display("FAIL %s timeout: writes %0d, required %0d",
               name, wr_q.size(), NW*jobs);
    end
    vec++;
    if (rd_q.size() != n*jobs) begin
      err++;
      $display("FAIL %s read count: got %0d, required %0d",
               name, rd_q.size(), n*jobs);
    end
    vec++;
    if (wr_q.size() != NW*jobs) begin
      err++;
      $display("FAIL %s write count: got %0d, required %0d",
               name, wr_q.size(), NW*jobs);
    end
    for (int k = 0; k < rd_q.size() && k < n*jobs; k++) begin
      vec++;
      if (rd_q[k].fa !== 14'((k % n) * 8) ||
          rd_q[k].wa !== 14'((k % n) * 8)) begin
        err++;
        $display("FAIL %s read %0d addr: got %0d/%0d, required %0d",
                 name, k, rd_q[k].fa, rd_q[k].wa, (k % n) * 8);
      end
      if (k < n) begin
        vec++;
        if (rd_q[k].cyc != launch_cyc + 1 + k) begin
          err++;
          $display("FAIL %s read %0d cycle: got %0d, required %0d",
                   name, k, rd_q[k].cyc, launch_cyc + 1 + k);
        end
      end
    end
    for (int w = 0; w < wr_q.size() && w < NW*jobs; w++) begin
      idx = w % NW;
      r = idx / 2;
      h = idx % 2;
      ea = 14'(r * c_line + h * 16);
      for (int m = 0; m < 4; m++)
        ew[m*32 +: 32] = exp_c[r][4*h + m];
      vec++;
      if (wr_q[w].addr !== ea || wr_q[w].data !== ew) begin
        err++;
        $display("FAIL %s write %0d: got %0d/%h, required %0d/%h",
                 name, w, wr_q[w].addr, wr_q[w].data, ea, ew);
      end
      if (idx > 0) begin
        vec++;
        if (wr_q[w].cyc != wr_q[w-1].cyc + 1) begin
          err++;
          $display("FAIL %s write %0d not consecutive: cycle %0d after %0d",
                   name, w, wr_q[w].cyc, wr_q[w-1].cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {8'd9, {7{8'(8 - k)}}};
      wmem[k] = 64'd1 << (8 * k);
    end
    ctrl_info = '0;
    ctrl_info.valid       = 1'b1;
    ctrl_info.a_line_size = 14'd8;
    ctrl_info.b_line_size = 14'd8;
    ctrl_info.c_line_size = 14'd64;
    ctrl_info.matrix_n    = 12'd8;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vec++;
      if (req_valid !== 1'b0 || output_we !== 1'b0 ||
          feature_addr !== '0 || weight_addr !== '0 ||
          output_addr !== '0 || output_data !== '0) begin
        err++;
        $display("FAIL reset outputs: req %b we %b fa %0d wa %0d oa %0d, required all 0",
                 req_valid, output_we, feature_addr, weight_addr, output_addr);
      end
    end
    do_job("identity", 8, 64, 1'b0);
    vec++;
    if (wr_q.size() >= 16 &&
        (wr_q[0].data !== {32'd5, 32'd6, 32'd7, 32'd8} ||
         wr_q[14].data !== {4{32'd9}} ||
         wr_q[15].addr !== 14'd464)) begin
      err++;
      $display("FAIL identity rows: got %h / %h @%0d, required row7 all 9 @464",
               wr_q[0].data, wr_q[14].data, wr_q[15].addr);
    end
  endtask

  task automatic test_single();
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {8{8'd3}};
      wmem[k] = {8{8'd5}};
    end
    do_job("n1", 1, 64, 1'b0);
    vec++;
    if (wr_q.size() > 9 && wr_q[9].data !== {4{32'd15}}) begin
      err++;
      $display("FAIL n1 value: got %h, required all 15", wr_q[9].data);
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {$urandom, $urandom};
      wmem[k] = {$urandom, $urandom};
    end
    do_job("n0", 0, 64, 1'b0);
  endtask

  task automatic test_abort();
    int t, nrd;
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {$urandom, $urandom};
      wmem[k] = {$urandom, $urandom};
    end
    @(negedge clk); #1;
    rd_q.delete();
    wr_q.delete();
    ctrl_info.valid       = 1'b1;
    ctrl_info.a_line_size = 14'd8;
    ctrl_info.b_line_size = 14'd8;
    ctrl_info.c_line_size = 14'd64;
    ctrl_info.matrix_n    = 12'd8;
    @(posedge clk);
    @(negedge clk); #1;
    ctrl_info.valid = 1'b0;
    t = 0;
    while (rd_q.size() < 4 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    rst = 1'b1;
    @(negedge clk); #1;
    vec++;
    if (t >= 100 || req_valid !== 1'b0 || output_we !== 1'b0 ||
        feature_addr !== '0 || weight_addr !== '0 ||
        output_addr !== '0 || output_data !== '0) begin
      err++;
      $display("FAIL abort outputs: t %0d req %b we %b fa %0d wa %0d, required reset values",
               t, req_valid, output_we, feature_addr, weight_addr);
    end
    nrd = rd_q.size();
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    vec++;
    if (rd_q.size() != nrd || wr_q.size() != 0) begin
      err++;
      $display("FAIL abort quiet: reads %0d writes %0d, required %0d and 0",
               rd_q.size(), wr_q.size(), nrd);
    end
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {8{8'd3}};
      wmem[k] = {8{8'd5}};
    end
    do_job("after_abort", 1, 64, 1'b0);
  endtask

  task automatic test_saturate();
    logic [31:0] want;
`ifdef MATRIX_MUL_SIGNED_EN
    want = 32'd8;
`else
    want = 32'd520200;
`endif
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {8{8'hFF}};
      wmem[k] = {8{8'hFF}};
    end
    do_job("saturate", 8, 64, 1'b0);
    vec++;
    if (wr_q.size() > 0 && wr_q[0].data[31:0] !== want) begin
      err++;
      $display("FAIL saturate C00: got %0d, required %0d",
               wr_q[0].data[31:0], want);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 8; k++) begin
        fmem[k] = {$urandom, $urandom};
        wmem[k] = {$urandom, $urandom};
      end
      do_job("random", int'($urandom_range(1, 8)),
             int'($urandom_range(0, 16383)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      fmem[k] = {$urandom, $urandom};
      wmem[k] = {$urandom, $urandom};
    end
    do_job("back_to_back", 3, 200, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_abort();
    test_saturate();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
